// File: rtl/srch_host_seq_pkg.sv
// Shared codes for the search-engine host sequencer: command ops, response
// status values and the sequencer FSM states.
package srch_if_pkg;

    typedef enum logic [1:0] {
        OP_WRITE  = 2'b00,
        OP_SEARCH = 2'b01,
        OP_CLEAR  = 2'b10,
        OP_RSVD   = 2'b11
    } cmd_op_e;

    typedef enum logic [2:0] {
        ST_WR_OK   = 3'd0,
        ST_HIT     = 3'd1,
        ST_MISS    = 3'd2,
        ST_FULL    = 3'd3,
        ST_EMPTY   = 3'd4,
        ST_TIMEOUT = 3'd5,
        ST_ILLEGAL = 3'd6
    } rsp_status_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WR,
        S_SRCH,
        S_WAIT,
        S_RSP
    } state_e;

endpackage

// File: rtl/srch_host_seq_if.sv
// Host command/response port of the search sequencer.
// master = host side, slave = sequencer side.
interface srch_host_seq_if #(
    parameter int DW = 8,
    parameter int AW = 8
);
    logic          cmd_valid;
    logic          cmd_ready;
    logic [1:0]    cmd_op;
    logic          cmd_mode;
    logic [DW-1:0] cmd_data;
    logic [AW-1:0] cmd_addr;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [2:0]    rsp_status;
    logic [AW-1:0] rsp_addr;

    modport master (
        output cmd_valid, cmd_op, cmd_mode, cmd_data, cmd_addr, rsp_ready,
        input  cmd_ready, rsp_valid, rsp_status, rsp_addr
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_mode, cmd_data, cmd_addr, rsp_ready,
        output cmd_ready, rsp_valid, rsp_status, rsp_addr
    );
endinterface

// File: rtl/srch_host_seq_tmo_cnt.sv
// Search timeout counter: cleared in the srch cycle, counts WAIT cycles,
// expire_o is high during the last (TMO_CYC-th) WAIT cycle.
module srch_tmo_cnt #(
    parameter int TMO_CYC = 1024
) (
    input  logic clk,
    input  logic reset,
    input  logic load_i,
    input  logic en_i,
    output logic expire_o
);
    localparam int TW = $clog2(TMO_CYC + 1);

    logic [TW-1:0] cnt_q, cnt_d;

    assign expire_o = (cnt_q == TW'(TMO_CYC - 1));

    // next count: clear on load, advance while waiting, saturate at expiry
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = '0;
        end else if (en_i && !expire_o) begin
            cnt_d = cnt_q + TW'(1);
        end
    end

    // count register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
endmodule

// File: rtl/srch_host_seq.sv
// Host-side initiator for the table store/search engine: one command in
// flight, one response per command, occupancy tracking and search timeout.
module srch_host_seq
    import srch_if_pkg::*;
#(
    parameter int          DW      = 8,
    parameter int          AW      = 8,
    parameter int          DEPTH   = 256,
    parameter int          TMO_CYC = 1024,
    parameter logic [AW-1:0] MISS_AD = 8'hFF
) (
    input  logic                         clk,
    input  logic                         reset,
    srch_host_seq_if.slave               host,
    output logic [$clog2(DEPTH+1)-1:0]   entry_cnt,
    output logic                         dtin,
    output logic [DW-1:0]                data,
    output logic [AW-1:0]                address,
    output logic                         srch,
    output logic [DW-1:0]                srdt,
    output logic                         M1_AO,
    input  logic                         op_sr,
    input  logic [AW-1:0]                out_mem_ad
);
    localparam int CW = $clog2(DEPTH + 1);

    state_e        state_q, state_d;
    rsp_status_e   status_q, status_d;
    logic [AW-1:0] raddr_q, raddr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [DW-1:0] data_q;
    logic [AW-1:0] addr_q;
    logic          mode_q;
    logic          tmo_expire;
    logic          accept;

    assign accept = host.cmd_valid && (state_q == S_IDLE);

    srch_tmo_cnt #(.TMO_CYC(TMO_CYC)) u_tmo (
        .clk      (clk),
        .reset    (reset),
        .load_i   (state_q == S_SRCH),
        .en_i     (state_q == S_WAIT),
        .expire_o (tmo_expire)
    );

    // state, response, occupancy and operand registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            status_q <= ST_WR_OK;
            raddr_q  <= '0;
            cnt_q    <= '0;
            data_q   <= '0;
            addr_q   <= '0;
            mode_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            status_q <= status_d;
            raddr_q  <= raddr_d;
            cnt_q    <= cnt_d;
            if (accept) begin
                data_q <= host.cmd_data;
                addr_q <= host.cmd_addr;
                mode_q <= host.cmd_mode;
            end
        end
    end

    // next state; response and occupancy are decided on the transition into RSP
    always_comb begin
        state_d  = state_q;
        status_d = status_q;
        raddr_d  = raddr_q;
        cnt_d    = cnt_q;
        unique case (state_q)
            S_IDLE: begin
                if (accept) begin
                    state_d = S_RSP;
                    raddr_d = '0;
                    unique case (cmd_op_e'(host.cmd_op))
                        OP_WRITE: begin
                            if (cnt_q == CW'(DEPTH)) status_d = ST_FULL;
                            else                     state_d  = S_WR;
                        end
                        OP_SEARCH: begin
                            if (cnt_q == '0) status_d = ST_EMPTY;
                            else             state_d  = S_SRCH;
                        end
                        OP_CLEAR: begin
                            cnt_d    = '0;
                            status_d = ST_WR_OK;
                        end
                        default: status_d = ST_ILLEGAL;
                    endcase
                end
            end
            S_WR: begin
                cnt_d    = cnt_q + CW'(1);
                state_d  = S_RSP;
                status_d = ST_WR_OK;
                raddr_d  = addr_q;
            end
            S_SRCH: state_d = S_WAIT;
            S_WAIT: begin
                // op_sr in the final counted cycle takes priority over expiry
                if (op_sr) begin
                    state_d = S_RSP;
                    if (out_mem_ad != MISS_AD) begin
                        status_d = ST_HIT;
                        raddr_d  = out_mem_ad;
                    end else begin
                        status_d = ST_MISS;
                        raddr_d  = '0;
                    end
                end else if (tmo_expire) begin
                    state_d  = S_RSP;
                    status_d = ST_TIMEOUT;
                    raddr_d  = '0;
                end
            end
            S_RSP: begin
                if (host.rsp_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // engine and host outputs decoded from the current state
    always_comb begin
        host.cmd_ready = (state_q == S_IDLE);
        host.rsp_valid = (state_q == S_RSP);
        dtin           = (state_q == S_WR);
        data           = (state_q == S_WR) ? data_q : '0;
        address        = (state_q == S_WR) ? addr_q : '0;
        srch           = (state_q == S_SRCH);
        srdt           = (state_q == S_SRCH || state_q == S_WAIT) ? data_q : '0;
        M1_AO          = (state_q == S_SRCH || state_q == S_WAIT) && mode_q;
    end

    assign host.rsp_status = status_q;
    assign host.rsp_addr   = raddr_q;
    assign entry_cnt       = cnt_q;
endmodule

// File: tb/tb_srch_host_seq.sv
// Directed bench for srch_host_seq with DEPTH=4 and TMO_CYC=16.
module tb_srch_host_seq;

    localparam logic [2:0] WR_OK = 3'd0, HIT = 3'd1, MISS = 3'd2, FULL = 3'd3,
                           EMPTY = 3'd4, TMO = 3'd5, ILL = 3'd6;
    localparam logic [1:0] W = 2'b00, S = 2'b01, C = 2'b10, R = 2'b11;

    logic       clk = 1'b0;
    logic       reset;
    logic [2:0] entry_cnt;
    logic       dtin, srch, M1_AO, op_sr;
    logic [7:0] data, address, srdt, out_mem_ad;

    always #5 clk = ~clk;

    srch_host_seq_if #(.DW(8), .AW(8)) host ();

    srch_host_seq #(
        .DW(8), .AW(8), .DEPTH(4), .TMO_CYC(16), .MISS_AD(8'hFF)
    ) dut (
        .clk(clk), .reset(reset), .host(host), .entry_cnt(entry_cnt),
        .dtin(dtin), .data(data), .address(address), .srch(srch),
        .srdt(srdt), .M1_AO(M1_AO), .op_sr(op_sr), .out_mem_ad(out_mem_ad)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // pin monitor, sampled mid-cycle
    int         n_dtin = 0, n_srch = 0, n_both = 0;
    logic [7:0] cap_data, cap_addr, cap_srdt;
    logic       cap_mode;
    always @(negedge clk) begin
        if (dtin) begin n_dtin++; cap_data = data; cap_addr = address; end
        if (srch) begin n_srch++; cap_srdt = srdt; cap_mode = M1_AO; end
        if (dtin && srch) n_both++;
    end

    // engine model: op_sr lands eng_delay cycles after the first WAIT cycle
    int         eng_delay = 0;
    logic [7:0] eng_ad = 8'h00;
    bit         eng_silent = 1'b0;
    initial begin
        op_sr = 1'b0;
        out_mem_ad = 8'h00;
        forever begin
            @(negedge clk);
            if (srch && !eng_silent) begin
                repeat (eng_delay + 1) @(posedge clk);
                #1 op_sr = 1'b1; out_mem_ad = eng_ad;
                @(posedge clk);
                #1 op_sr = 1'b0;
            end
        end
    end

    task automatic do_cmd(input logic [1:0] op, input logic mode, input logic [7:0] d,
                          input logic [7:0] a, output int lat);
        host.cmd_valid = 1'b1;
        host.cmd_op    = op;
        host.cmd_mode  = mode;
        host.cmd_data  = d;
        host.cmd_addr  = a;
        tick;
        host.cmd_valid = 1'b0;
        lat = 1;
        chk("cmd_ready_busy", host.cmd_ready, 1'b0);
        while (!host.rsp_valid && lat < 100) begin
            tick;
            lat++;
        end
    endtask

    task automatic accept_rsp;
        host.rsp_ready = 1'b1;
        tick;
        host.rsp_ready = 1'b0;
        chk("idle_ready", host.cmd_ready, 1'b1);
        chk("idle_rsp_valid", host.rsp_valid, 1'b0);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_cmd_ready"}, host.cmd_ready, 1'b1);
        chk({tag, "_rsp_valid"}, host.rsp_valid, 1'b0);
        chk({tag, "_rsp_status"}, host.rsp_status, 3'd0);
        chk({tag, "_rsp_addr"}, host.rsp_addr, 8'h00);
        chk({tag, "_entry_cnt"}, entry_cnt, 3'd0);
        chk({tag, "_dtin"}, dtin, 1'b0);
        chk({tag, "_data"}, data, 8'h00);
        chk({tag, "_address"}, address, 8'h00);
        chk({tag, "_srch"}, srch, 1'b0);
        chk({tag, "_srdt"}, srdt, 8'h00);
        chk({tag, "_M1_AO"}, M1_AO, 1'b0);
    endtask

    typedef struct {
        logic [1:0] op;
        logic       mode;
        logic [7:0] d;
        logic [7:0] a;
        int         dly;
        logic [7:0] ead;
        bit         silent;
        logic [2:0] st;
        logic [7:0] ra;
        int         cnt;
        int         lat;
        int         ndt;
        int         nsr;
    } vec_t;

    vec_t v[15];

    initial begin
        int lat, dt0, sr0, cnt_before;

        v[0]  = '{W, 1'b0, 8'h3C, 8'h05,  0, 8'h00, 1'b0, WR_OK, 8'h05, 1,  2, 1, 0};
        v[1]  = '{S, 1'b1, 8'h3C, 8'h00,  4, 8'h05, 1'b0, HIT,   8'h05, 1,  7, 0, 1};
        v[2]  = '{S, 1'b0, 8'h11, 8'h00,  2, 8'hFF, 1'b0, MISS,  8'h00, 1,  5, 0, 1};
        v[3]  = '{S, 1'b1, 8'h22, 8'h00,  0, 8'h00, 1'b1, TMO,   8'h00, 1, 18, 0, 1};
        v[4]  = '{S, 1'b0, 8'h33, 8'h00, 15, 8'h02, 1'b0, HIT,   8'h02, 1, 18, 0, 1};
        v[5]  = '{S, 1'b1, 8'h44, 8'h00, 16, 8'h03, 1'b0, TMO,   8'h00, 1, 18, 0, 1};
        v[6]  = '{W, 1'b0, 8'hA1, 8'h10,  0, 8'h00, 1'b0, WR_OK, 8'h10, 2,  2, 1, 0};
        v[7]  = '{W, 1'b0, 8'hB2, 8'h20,  0, 8'h00, 1'b0, WR_OK, 8'h20, 3,  2, 1, 0};
        v[8]  = '{W, 1'b0, 8'hC3, 8'h30,  0, 8'h00, 1'b0, WR_OK, 8'h30, 4,  2, 1, 0};
        v[9]  = '{W, 1'b0, 8'hD4, 8'h40,  0, 8'h00, 1'b0, FULL,  8'h00, 4,  1, 0, 0};
        v[10] = '{R, 1'b0, 8'h00, 8'h00,  0, 8'h00, 1'b0, ILL,   8'h00, 4,  1, 0, 0};
        v[11] = '{C, 1'b0, 8'h00, 8'h00,  0, 8'h00, 1'b0, WR_OK, 8'h00, 0,  1, 0, 0};
        v[12] = '{S, 1'b1, 8'h3C, 8'h00,  0, 8'h05, 1'b0, EMPTY, 8'h00, 0,  1, 0, 0};
        v[13] = '{W, 1'b0, 8'h55, 8'h07,  0, 8'h00, 1'b0, WR_OK, 8'h07, 1,  2, 1, 0};
        v[14] = '{S, 1'b0, 8'h55, 8'h00,  0, 8'h07, 1'b0, HIT,   8'h07, 1,  3, 0, 1};

        reset = 1'b0;
        host.cmd_valid = 1'b0; host.cmd_op = 2'b00; host.cmd_mode = 1'b0;
        host.cmd_data = 8'h00; host.cmd_addr = 8'h00; host.rsp_ready = 1'b0;
        tick; tick;
        chk_all_zero("reset");
        reset = 1'b1;
        tick;

        for (int i = 0; i < 15; i++) begin
            eng_delay  = v[i].dly;
            eng_ad     = v[i].ead;
            eng_silent = v[i].silent;
            dt0 = n_dtin;
            sr0 = n_srch;
            do_cmd(v[i].op, v[i].mode, v[i].d, v[i].a, lat);
            chk($sformatf("v%0d_latency", i), lat, v[i].lat);
            chk($sformatf("v%0d_status", i), host.rsp_status, v[i].st);
            chk($sformatf("v%0d_rsp_addr", i), host.rsp_addr, v[i].ra);
            chk($sformatf("v%0d_entry_cnt", i), entry_cnt, v[i].cnt);
            chk($sformatf("v%0d_dtin_pulses", i), n_dtin - dt0, v[i].ndt);
            chk($sformatf("v%0d_srch_pulses", i), n_srch - sr0, v[i].nsr);
            if (v[i].ndt != 0) begin
                chk($sformatf("v%0d_wr_data", i), cap_data, v[i].d);
                chk($sformatf("v%0d_wr_address", i), cap_addr, v[i].a);
            end
            if (v[i].nsr != 0) begin
                chk($sformatf("v%0d_srdt", i), cap_srdt, v[i].d);
                chk($sformatf("v%0d_M1_AO", i), cap_mode, v[i].mode);
            end
            accept_rsp;
        end

        // spurious op_sr while idle
        sr0 = n_srch;
        cnt_before = 1;
        op_sr = 1'b1; out_mem_ad = 8'h03;
        tick; tick; tick;
        chk("spur_rsp_valid", host.rsp_valid, 1'b0);
        chk("spur_cmd_ready", host.cmd_ready, 1'b1);
        op_sr = 1'b0;
        tick;
        chk("spur_srch", n_srch - sr0, 0);
        chk("spur_entry_cnt", entry_cnt, cnt_before);
        chk("spur_rsp_valid_after", host.rsp_valid, 1'b0);

        // response stall: outputs frozen while rsp_ready is low
        do_cmd(W, 1'b0, 8'h66, 8'h09, lat);
        chk("stall_latency", lat, 2);
        for (int k = 0; k < 10; k++) begin
            tick;
            chk("stall_rsp_valid", host.rsp_valid, 1'b1);
            chk("stall_status", host.rsp_status, WR_OK);
            chk("stall_rsp_addr", host.rsp_addr, 8'h09);
            chk("stall_cmd_ready", host.cmd_ready, 1'b0);
        end
        chk("stall_entry_cnt", entry_cnt, 3'd2);
        accept_rsp;

        // asynchronous reset while waiting on the engine
        eng_silent = 1'b1;
        host.cmd_valid = 1'b1; host.cmd_op = S; host.cmd_mode = 1'b1;
        host.cmd_data = 8'h9A; host.cmd_addr = 8'h00;
        tick;
        host.cmd_valid = 1'b0;
        tick; tick; tick;
        chk("wait_srdt", srdt, 8'h9A);
        chk("wait_M1_AO", M1_AO, 1'b1);
        chk("wait_rsp_valid", host.rsp_valid, 1'b0);
        #2 reset = 1'b0;
        #1 chk_all_zero("midreset");
        tick; tick;
        reset = 1'b1;
        eng_silent = 1'b0;
        tick;
        chk("post_reset_rsp_valid", host.rsp_valid, 1'b0);
        dt0 = n_dtin;
        do_cmd(W, 1'b0, 8'h77, 8'h0A, lat);
        chk("post_latency", lat, 2);
        chk("post_status", host.rsp_status, WR_OK);
        chk("post_rsp_addr", host.rsp_addr, 8'h0A);
        chk("post_entry_cnt", entry_cnt, 3'd1);
        chk("post_dtin_pulses", n_dtin - dt0, 1);
        chk("post_wr_data", cap_data, 8'h77);
        chk("post_wr_address", cap_addr, 8'h0A);
        accept_rsp;

        chk("dtin_srch_overlap", n_both, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
